// File: rtl/cpu_pkg.sv
// Shared pipeline constants and types for the p6 core.
package cpu_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_pair_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-to-decode handshake bundle: fetch side (in_*), decode side (out_*), plus flush.
interface fetch_queue_if;

  logic        in_valid;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic [31:0] out_pc;
  logic [31:0] out_pc8;
  logic [31:0] out_instr;
  logic        out_ready;
  logic        flush;

  modport master (
    output in_valid, in_pc, in_instr, out_ready, flush,
    input  in_ready, out_valid, out_pc, out_pc8, out_instr
  );

  modport slave (
    input  in_valid, in_pc, in_instr, out_ready, flush,
    output in_ready, out_valid, out_pc, out_pc8, out_instr
  );

endinterface

// File: rtl/fetch_queue.sv
// Small circular instruction fetch queue between PC/imem and decode; flush empties it.
module fetch_queue
  import cpu_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.slave  bus
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] COUNT_FULL = DEPTH[PTR_W:0];

  fetch_pair_t      mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q;

  logic        push, pop;
  logic [31:0] head_pc;

  // Ready depends on registered occupancy only, so no out_ready -> in_ready path.
  assign bus.in_ready  = (count_q != COUNT_FULL);
  assign bus.out_valid = (count_q != '0);

  assign push = bus.in_valid  && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  assign head_pc       = bus.out_valid ? mem_q[rd_ptr_q].pc : RESET_PC;
  assign bus.out_pc    = head_pc;
  assign bus.out_pc8   = head_pc + 32'd8;
  assign bus.out_instr = bus.out_valid ? mem_q[rd_ptr_q].instr : NOP_INSTR;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (bus.flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Storage has no reset; contents are only observed while counted as valid.
  always_ff @(posedge clk) begin
    if (rst && !bus.flush && push) begin
      mem_q[wr_ptr_q] <= '{pc: bus.in_pc, instr: bus.in_instr};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: directed test-plan sequences followed by random traffic.
module tb_fetch_queue;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_queue_if bus ();

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } pair_t;

  pair_t sb[$];
  int    n_cmp = 0;
  int    n_err = 0;
  bit    started = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // Reference model: an abstract queue of accepted pairs, updated at each rising edge.
  always @(posedge clk) begin
    if (!rst) begin
      sb.delete();
      started <= 1'b1;
    end else if (bus.flush) begin
      sb.delete();
    end else begin
      bit acc;
      acc = bus.in_valid && (sb.size() < DEPTH);
      if (bus.out_ready && sb.size() > 0) void'(sb.pop_front());
      if (acc) sb.push_back('{pc: bus.in_pc, instr: bus.in_instr});
    end
  end

  // Monitor: compares DUT outputs with the head of the scoreboard mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (started) begin
        logic [31:0] epc, eins;
        epc  = (sb.size() > 0) ? sb[0].pc    : 32'h0000_3000;
        eins = (sb.size() > 0) ? sb[0].instr : 32'h0000_0000;
        chk("in_ready",  {31'b0, bus.in_ready},  {31'b0, sb.size() != DEPTH});
        chk("out_valid", {31'b0, bus.out_valid}, {31'b0, sb.size() != 0});
        chk("out_pc",    bus.out_pc,    epc);
        chk("out_pc8",   bus.out_pc8,   epc + 32'd8);
        chk("out_instr", bus.out_instr, eins);
      end
    end
  end

  task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                      input logic rdy, input logic fl, input logic rs);
    bus.in_valid  = v;
    bus.in_pc     = pc;
    bus.in_instr  = ins;
    bus.out_ready = rdy;
    bus.flush     = fl;
    rst           = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy);
    step(1'b0, 32'h0, 32'h0, rdy, 1'b0, 1'b1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_pc     = '0;
    bus.in_instr  = '0;
    bus.out_ready = 1'b0;
    bus.flush     = 1'b0;

    // Reset then idle
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    idle(1'b1);

    // Streaming with decode always ready
    step(1'b1, 32'h3000, 32'h2408_0001, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h3004, 32'h2409_0002, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h3008, 32'h0109_5020, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Stall: fill, hold the third fetch until a slot frees
    step(1'b1, 32'h3000, 32'h2408_0001, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3004, 32'h2409_0002, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3008, 32'h0109_5020, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3008, 32'h0109_5020, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3008, 32'h0109_5020, 1'b1, 1'b0, 1'b1);
    step(1'b1, 32'h3008, 32'h0109_5020, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Flush with a concurrent push
    step(1'b1, 32'h3000, 32'h1111_0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3004, 32'h1111_0004, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h3008, 32'h1111_0008, 1'b0, 1'b1, 1'b1);
    step(1'b1, 32'h3100, 32'h2222_0000, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Wrap pointers and the pc+8 adder
    for (int i = 0; i < 9; i++) begin
      step(1'b1, 32'hFFFF_FFFC - 32'(4 * (8 - i)), 32'(i) ^ 32'hA5A5_0000, 1'b1, 1'b0, 1'b1);
    end
    idle(1'b0);
    idle(1'b1);

    // Reset mid-operation (reset wins over flush and push)
    step(1'b1, 32'h4000, 32'h3333_0000, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4004, 32'h3333_0004, 1'b0, 1'b0, 1'b1);
    step(1'b1, 32'h4008, 32'h3333_0008, 1'b0, 1'b1, 1'b0);
    step(1'b1, 32'h3000, 32'h2408_0001, 1'b0, 1'b0, 1'b1);
    idle(1'b1);
    idle(1'b1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 63) != 0));
    end
    idle(1'b1);
    idle(1'b1);

    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Two-entry instruction fetch queue between the PC/instruction-memory stage and the decode stage of the p6 pipeline. Captures each fetched (PC, instruction) pair, presents the oldest pair to decode, absorbs decode stalls without losing a fetch, and discards all buffered fetches on a control-flow flush. Its `in_ready` drives the PC register's enable, so a full queue freezes fetch.

## Interface
- `DEPTH`, 2: number of entries; power of two, at least 2.
- `clk`  input  1  rising-edge clock.
- `rst`  input  1  synchronous reset, active-low (reset when `rst`=0 at a rising edge of `clk`).
- `in_valid`  input  1  fetch stage presents a valid pair.
- `in_pc`  input  32  PC of the fetched instruction.
- `in_instr`  input  32  instruction word from instruction memory.
- `in_ready`  output  1  queue accepts a pair this cycle; drives PC `en`.
- `out_valid`  output  1  head entry valid.
- `out_pc`  output  32  PC of the head entry.
- `out_pc8`  output  32  `out_pc` + 8, the link address for jal/jalr.
- `out_instr`  output  32  instruction of the head entry.
- `out_ready`  input  1  decode consumes the head this cycle (decode not stalled).
- `flush`  input  1  discard every entry (branch/jump redirect).

## Operation
- Storage: `DEPTH` entries of {pc, instr}, a write pointer, a read pointer, and an occupancy count of width log2(`DEPTH`)+1. Pointers wrap modulo `DEPTH`.
- Push happens when `in_valid` && `in_ready`. The pair is written at the write pointer, and the write pointer increments.
- Pop happens when `out_valid` && `out_ready`. The read pointer increments.
- `in_ready` = (count != `DEPTH`). It depends only on registered state; there is no combinational path from `out_ready` to `in_ready`.
- `out_valid` = (count != 0).
- `out_pc` and `out_instr` show the entry at the read pointer. When the queue is empty they hold 32'h0000_3000 and 32'h0000_0000 (nop).
- `out_pc8` = `out_pc` + 32'd8, mod 2^32. Wrap-around is allowed.
- Count update:
  - push only: +1.
  - pop only: −1.
  - push and pop together: unchanged.
- Simultaneous events:
  - Full with a pop: no push in the same cycle, because `in_ready`=0. After the pop, `in_ready`=1 in the next cycle.
  - Empty with `in_valid`: the pair is written. It is not bypassed, so `out_valid` rises one cycle later.
- `flush` has priority over push and pop. At the next edge the count and both pointers are 0, and any push in the same cycle is dropped. `in_ready` may be 1 during a flush cycle; the dropped fetch is the wrong-path instruction.
- Reset has priority over `flush`. A reset in the middle of any occupancy leaves the queue empty, and the stored data is don't-care.

## Timing
- Reset values:
  - `in_ready`=1
  - `out_valid`=0
  - `out_pc`=32'h0000_3000
  - `out_pc8`=32'h0000_3008
  - `out_instr`=0
- Latency is 1 cycle: a pair pushed at edge N is on `out_*` with `out_valid`=1 after edge N, and can be popped in cycle N+1.
- Throughput: one push and one pop per cycle at steady state, with no bubbles while not full.
- A stall (`out_ready`=0) for k cycles holds `out_*` stable. At most `DEPTH` pairs are accepted, then `in_ready`=0 until a pop.
- After a flush, `out_valid`=0 for at least one cycle. The first post-flush push is visible one cycle after it is accepted.

## Structure
- The shared package `cpu_pkg` holds:
  - `RESET_PC` = 32'h0000_3000, shared with the PC register.
  - `NOP_INSTR` = 32'h0000_0000.
  - A packed struct `fetch_pair_t` {pc[31:0], instr[31:0]}.
- No sub-module. Pointers, count and storage are local to `fetch_queue`.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles → `in_ready`=1, `out_valid`=0, `out_pc`=0x3000, `out_pc8`=0x3008, `out_instr`=0.
- Streaming: push pc 0x3000/0x3004/0x3008 (instr 0x24080001, 0x24090002, 0x01095020) on consecutive cycles with `out_ready`=1 → each appears one cycle later, in order, and `in_ready` stays 1.
- Stall: `out_ready`=0 while pushing 0x3000, 0x3004, 0x3008 → the first two are accepted, `in_ready`=0 on the third cycle, and the head holds 0x3000. Raise `out_ready` → 0x3000 then 0x3004 are popped, and 0x3008 is accepted one cycle after the first pop.
- Flush with concurrent push: queue holds 0x3000/0x3004; assert `flush` with push 0x3008 → next cycle `out_valid`=0 and count 0. Then push 0x3100 → it appears as head the following cycle.
- Wrap and arithmetic: run 9 push/pop cycles so the pointers wrap, ending with `in_pc`=0xFFFF_FFFC → order is preserved and `out_pc8`=0x0000_0004.
- Reset mid-operation: full queue, `rst`=0 for 1 cycle with `flush`=1 → empty with reset values. Then push 0x3000 → seen on the next cycle.
